pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Program-counter stage of the single-cycle MIPS core. It sits directly upstream of instruction ROM and decode/extension/writeback logic.
- Holds the PC and selects the next PC: sequential, taken branch, j/jal, or jr.
- Runs the syscall halt/resume state machine that gates PC advance.
- Keeps the performance counters (cycles run, jumps retired, taken branches) shown on the board display.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_WIDTH, 32, width of each statistics counter.
- PRINT_CODE, 32'h0000_0022, syscall service code ($v0) that does not halt.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- syscall  in  1  decoded current instruction is syscall.
- r1_out  in  32  register read port 1 data (the $v0 value during syscall).
- go  in  1  resume button level, already debounced and synchronous to clk.
- jmp  in  1  current instruction is j or jal.
- jr  in  1  current instruction is jr.
- branch_taken  in  1  current instruction is beq/bne and its condition is true.
- ext18  in  32  sign-extended offset shifted left by 2.
- instr_index  in  26  instruction bits [25:0].
- jr_target  in  32  register value for jr.
- pc  out  32  current PC, which is the ROM address.
- pc_plus_4  out  32  pc+4, used for the jal link value.
- halted  out  1  core is stopped on a syscall.
- cycle_cnt  out  CNT_WIDTH  clocks spent in RUN.
- jump_cnt  out  CNT_WIDTH  retired j/jal/jr.
- branch_cnt  out  CNT_WIDTH  retired taken branches.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=RESET_PC.
  - State=RUN, halted=0.
  - All counters=0, go_q=0.
- pc_plus_4 = pc+32'd4, combinational. All arithmetic is mod 2^32, so 32'hFFFF_FFFC+4 wraps to 0.
- go_q is registered go. go_rise = go & ~go_q.
- FSM states: RUN, HALT.
  - RUN, syscall=1 and r1_out!=PRINT_CODE:
    - Go to HALT next edge.
    - pc holds.
    - cycle_cnt increments for this cycle.
  - RUN, syscall=1 and r1_out==PRINT_CODE: treated as an ordinary sequential instruction, pc<=pc_plus_4.
  - RUN, otherwise: pc<=next_pc, cycle_cnt+=1.
  - HALT: pc and all counters hold, halted=1.
  - HALT with go_rise: go to RUN and pc<=pc_plus_4 (step past the syscall). cycle_cnt does not increment on this edge.
- go level is ignored. If go is already high when the halt occurs, the core stays halted until go is released and pressed again.
- next_pc priority in RUN, highest first:
  - jr: {jr_target[31:2],2'b00}. Misaligned targets are silently word-aligned.
  - jmp: {pc_plus_4[31:28], instr_index, 2'b00}.
  - branch_taken: pc_plus_4 + ext18.
  - else pc_plus_4.
- Counters, RUN only:
  - jump_cnt += 1 when jr or jmp selects next_pc.
  - branch_cnt += 1 only when branch_taken wins priority, i.e. jr=0 and jmp=0.
  - Counters wrap at 2^CNT_WIDTH; they do not saturate.
- Control inputs jmp/jr/branch_taken are ignored while syscall=1 (syscall decode wins).
- halted is a registered output, equal to (state==HALT).
- Reset asserted during HALT: returns to RUN at RESET_PC immediately, asynchronously.

Decomposition:
- Shared package cpu_pkg holds:
  - the state encoding (RUN=1'b0, HALT=1'b1);
  - constants RESET_PC_DEFAULT and PRINT_CODE_DEFAULT;
  - the next-PC select enum (NPC_SEQ, NPC_BR, NPC_J, NPC_JR).
- One sub-module is natural: pc_next_sel, a purely combinational priority mux producing next_pc and the select code. The FSM, PC register and counters stay in pc_unit.

Test Plan:
- Reset then 3 cycles with no control -> pc 0x0, 0x4, 0x8, 0xC; cycle_cnt=3; jump_cnt=0, branch_cnt=0.
- pc=0x0040_0010, branch_taken=1, ext18=32'hFFFF_FFF8 -> next pc=0x0040_000C; branch_cnt=1. Repeat with jmp=1 as well, instr_index=26'h10_0000 -> pc=0x0040_0000; jump_cnt+1, branch_cnt unchanged.
- jr=1, jr_target=0x0000_1237 -> pc=0x0000_1234; jump_cnt increments.
- syscall=1, r1_out=0x0A at pc=0x20 -> halted=1 next edge; pc stays 0x20 for 10 cycles; cycle_cnt frozen. Pulse go for 1 cycle -> pc=0x24, halted=0.
- syscall=1, r1_out=0x22 at pc=0x30 -> no halt, pc=0x34. With go held high before a halting syscall -> stays halted until go goes 0 then 1.
- Assert rst_n=0 mid-HALT between clock edges -> pc=RESET_PC, halted=0 and counters=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the single-cycle MIPS core front end.
//   - state_e    : PC-stage run/halt state encoding
//   - npc_sel_e  : which source produced the next PC
//   - RESET_PC_DEFAULT, PRINT_CODE_DEFAULT : default parameter values
//   - JR_ALIGN_MASK : clears the byte-offset bits of a jr target
// -----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam logic [31:0] PRINT_CODE_DEFAULT = 32'h0000_0022;
  localparam logic [31:0] JR_ALIGN_MASK      = 32'hFFFF_FFFC;

endpackage : cpu_pkg

// File: rtl/pc_next_sel.sv
// -----------------------------------------------------------------------------
// pc_next_sel
// Purely combinational next-PC priority mux (jr > j/jal > taken branch > seq).
// Ports:
//   pc_plus_4    in  32  current pc + 4
//   jr           in  1   instruction is jr
//   jmp          in  1   instruction is j or jal
//   branch_taken in  1   taken beq/bne
//   ext18        in  32  sign-extended branch offset, already << 2
//   instr_index  in  26  jump target index
//   jr_target    in  32  register value for jr
//   next_pc      out 32  selected next PC
//   sel          out 2   which source won (npc_sel_e)
// -----------------------------------------------------------------------------
module pc_next_sel
  import cpu_pkg::*;
(
  input  logic [31:0] pc_plus_4,
  input  logic        jr,
  input  logic        jmp,
  input  logic        branch_taken,
  input  logic [31:0] ext18,
  input  logic [25:0] instr_index,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output npc_sel_e    sel
);

  always_comb begin
    next_pc = pc_plus_4;
    sel     = NPC_SEQ;
    if (jr) begin
      // Misaligned register targets are forced onto a word boundary.
      next_pc = jr_target & JR_ALIGN_MASK;
      sel     = NPC_JR;
    end else if (jmp) begin
      next_pc = {pc_plus_4[31:28], instr_index, 2'b00};
      sel     = NPC_J;
    end else if (branch_taken) begin
      next_pc = pc_plus_4 + ext18;
      sel     = NPC_BR;
    end
  end

endmodule : pc_next_sel

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
// Program-counter stage: PC register, next-PC selection, syscall halt/resume
// state machine and performance counters.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   syscall, r1_out     syscall decode and $v0 value
//   go                  resume button level (debounced, synchronous)
//   jmp, jr, branch_taken, ext18, instr_index, jr_target : next-PC controls
//   pc, pc_plus_4       current PC (ROM address) and pc+4 (jal link)
//   halted              core stopped on a syscall (registered)
//   cycle_cnt, jump_cnt, branch_cnt : statistics counters (wrap)
// -----------------------------------------------------------------------------
module pc_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          CNT_WIDTH  = 32,
  parameter logic [31:0] PRINT_CODE = PRINT_CODE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 syscall,
  input  logic [31:0]          r1_out,
  input  logic                 go,
  input  logic                 jmp,
  input  logic                 jr,
  input  logic                 branch_taken,
  input  logic [31:0]          ext18,
  input  logic [25:0]          instr_index,
  input  logic [31:0]          jr_target,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus_4,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] jump_cnt,
  output logic [CNT_WIDTH-1:0] branch_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic                   go_q;
  logic [31:0]            pc_q, pc_d;
  logic [CNT_WIDTH-1:0]   cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0]   jump_q, jump_d;
  logic [CNT_WIDTH-1:0]   branch_q, branch_d;

  logic [31:0]            next_pc;
  npc_sel_e               npc_sel;
  logic                   go_rise;
  logic                   halt_req;

  assign pc_plus_4 = pc_q + 32'd4;
  // Only a fresh press resumes; a button already held at halt time is ignored.
  assign go_rise   = go & ~go_q;
  // The print service returns immediately instead of halting.
  assign halt_req  = syscall && (r1_out != PRINT_CODE);

  pc_next_sel u_next_sel (
    .pc_plus_4    (pc_plus_4),
    .jr           (jr),
    .jmp          (jmp),
    .branch_taken (branch_taken),
    .ext18        (ext18),
    .instr_index  (instr_index),
    .jr_target    (jr_target),
    .next_pc      (next_pc),
    .sel          (npc_sel)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (halt_req) state_d = ST_HALT;
      ST_HALT: if (go_rise)  state_d = ST_RUN;
    endcase
  end

  // Datapath next values driven by the current state
  always_comb begin
    pc_d     = pc_q;
    cycle_d  = cycle_q;
    jump_d   = jump_q;
    branch_d = branch_q;
    case (state_q)
      ST_RUN: begin
        cycle_d = cycle_q + CNT_ONE;
        if (syscall) begin
          // Syscall decode overrides jump/branch controls; a halting
          // syscall keeps pc so resume can step past it.
          if (!halt_req) pc_d = pc_plus_4;
        end else begin
          pc_d = next_pc;
          if (npc_sel == NPC_J || npc_sel == NPC_JR) jump_d = jump_q + CNT_ONE;
          if (npc_sel == NPC_BR) branch_d = branch_q + CNT_ONE;
        end
      end
      ST_HALT: begin
        if (go_rise) pc_d = pc_plus_4;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_q     <= 1'b0;
      pc_q     <= RESET_PC;
      cycle_q  <= '0;
      jump_q   <= '0;
      branch_q <= '0;
    end else begin
      go_q     <= go;
      pc_q     <= pc_d;
      cycle_q  <= cycle_d;
      jump_q   <= jump_d;
      branch_q <= branch_d;
    end
  end

  assign pc         = pc_q;
  assign halted     = (state_q == ST_HALT);
  assign cycle_cnt  = cycle_q;
  assign jump_cnt   = jump_q;
  assign branch_cnt = branch_q;

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit
// Directed self-checking bench for pc_unit with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        syscall;
  logic [31:0] r1_out;
  logic        go;
  logic        jmp;
  logic        jr;
  logic        branch_taken;
  logic [31:0] ext18;
  logic [25:0] instr_index;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic        halted;
  logic [31:0] cycle_cnt;
  logic [31:0] jump_cnt;
  logic [31:0] branch_cnt;

  int check_cnt = 0;
  int err_cnt   = 0;

  pc_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .syscall      (syscall),
    .r1_out       (r1_out),
    .go           (go),
    .jmp          (jmp),
    .jr           (jr),
    .branch_taken (branch_taken),
    .ext18        (ext18),
    .instr_index  (instr_index),
    .jr_target    (jr_target),
    .pc           (pc),
    .pc_plus_4    (pc_plus_4),
    .halted       (halted),
    .cycle_cnt    (cycle_cnt),
    .jump_cnt     (jump_cnt),
    .branch_cnt   (branch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    check_cnt++;
    if (obs !== exp_v) begin
      err_cnt++;
      $display("FAIL %s got %h want %h", tag, obs, exp_v);
    end else begin
      $display("ok   %s = %h", tag, obs);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    syscall = 0; r1_out = 0; jmp = 0; jr = 0; branch_taken = 0;
    ext18 = 0; instr_index = 0; jr_target = 0;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] e_pc, input logic e_halt,
                           input logic [31:0] e_cyc, input logic [31:0] e_jmp,
                           input logic [31:0] e_br);
    chk({tag, ".pc"},     pc,         e_pc);
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, e_halt});
    chk({tag, ".cycle"},  cycle_cnt,  e_cyc);
    chk({tag, ".jump"},   jump_cnt,   e_jmp);
    chk({tag, ".branch"}, branch_cnt, e_br);
  endtask

  initial begin
    rst_n = 1'b0;
    go    = 1'b0;
    idle();
    #12;
    rst_n = 1'b1;
    chk_state("reset", 32'h0, 1'b0, 0, 0, 0);
    chk("reset.pc4", pc_plus_4, 32'h4);

    // Sequential advance
    step(); chk("seq1.pc", pc, 32'h4);
    step(); chk("seq2.pc", pc, 32'h8);
    step(); chk_state("seq3", 32'hC, 1'b0, 3, 0, 0);

    // j to 0x0040_0010
    jmp = 1; instr_index = 26'h10_0004;
    step(); chk_state("j", 32'h0040_0010, 1'b0, 4, 1, 0);

    // backward taken branch
    idle(); branch_taken = 1; ext18 = 32'hFFFF_FFF8;
    step(); chk_state("beq", 32'h0040_000C, 1'b0, 5, 1, 1);

    // jmp outranks branch
    jmp = 1; instr_index = 26'h10_0000;
    step(); chk_state("j_over_br", 32'h0040_0000, 1'b0, 6, 2, 1);

    // jr outranks both, misaligned target aligned
    jr = 1; jr_target = 32'h0000_1237;
    step(); chk_state("jr", 32'h0000_1234, 1'b0, 7, 3, 1);

    // move to 0x20 then halting syscall (jmp ignored under syscall)
    idle(); jr = 1; jr_target = 32'h20;
    step(); chk("jr20.pc", pc, 32'h20);
    idle(); syscall = 1; r1_out = 32'h0A; jmp = 1; instr_index = 26'h3FF;
    step(); chk_state("halt", 32'h20, 1'b1, 9, 4, 1);
    idle();
    for (int i = 0; i < 10; i++) begin
      step(); chk("halt_hold.pc", pc, 32'h20);
    end
    chk_state("halt_end", 32'h20, 1'b1, 9, 4, 1);
    go = 1;
    step(); chk_state("resume", 32'h24, 1'b0, 9, 4, 1);
    go = 0;
    step(); chk_state("after_resume", 32'h28, 1'b0, 10, 4, 1);

    // print syscall does not halt, controls ignored
    jr = 1; jr_target = 32'h30;
    step(); chk("jr30.pc", pc, 32'h30);
    idle(); syscall = 1; r1_out = 32'h22; branch_taken = 1; ext18 = 32'h100;
    step(); chk_state("print", 32'h34, 1'b0, 12, 5, 1);

    // go held high across halt: level ignored
    idle(); go = 1;
    step(); chk("gohi.pc", pc, 32'h38);
    syscall = 1; r1_out = 32'h0A;
    step(); chk_state("halt2", 32'h38, 1'b1, 14, 5, 1);
    idle();
    for (int i = 0; i < 3; i++) begin
      step(); chk("held.halted", {31'd0, halted}, 32'd1);
    end
    go = 0;
    step(); chk_state("released", 32'h38, 1'b1, 14, 5, 1);
    go = 1;
    step(); chk_state("pressed", 32'h3C, 1'b0, 14, 5, 1);
    go = 0;

    // halt then async reset between edges
    syscall = 1; r1_out = 32'h0;
    step(); chk_state("halt3", 32'h3C, 1'b1, 15, 5, 1);
    idle();
    #3;
    rst_n = 1'b0;
    #1;
    chk_state("async_rst", 32'h0, 1'b0, 0, 0, 0);
    #2;
    rst_n = 1'b1;

    // wrap of pc at top of address space
    jr = 1; jr_target = 32'hFFFF_FFFF;
    step(); chk("top.pc", pc, 32'hFFFF_FFFC);
    chk("top.pc4", pc_plus_4, 32'h0);
    idle();
    step(); chk_state("wrap", 32'h0, 1'b0, 2, 1, 0);

    $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
    $finish;
  end

endmodule : tb_pc_unit
